// File: rtl/psg_write_queue.sv
`timescale 1ns/1ps
// psg_write_queue
// Bus-side write buffer and strobe sequencer in front of the PSG.
// CPU command bytes are captured into a DEPTH-entry FIFO at bus speed and
// replayed one at a time onto the PSG nWE/nCE/D port, paced by PSG_READY.
// Optional feature macro: PSG_WRQ_OVF_EN builds the sticky overflow flag
// BUS_OVF. When it is undefined, BUS_OVF is tied low and no flop is built.
module psg_write_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       BUS_WR,
  input  logic [7:0] BUS_D,
  output logic       BUS_FULL,
  output logic       BUS_OVF,
  output logic       PSG_nWE,
  output logic       PSG_nCE,
  output logic [7:0] PSG_D,
  input  logic       PSG_READY
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT_LO
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               nwe_q, nwe_d;
  logic [7:0]         psg_d_q, psg_d_d;
  logic               full;
  logic               push;
  logic               pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign BUS_FULL = full;
  assign PSG_nWE  = nwe_q;
  assign PSG_nCE  = nwe_q;
  assign PSG_D    = psg_d_q;

  // Strobe sequencer: launch a one-cycle strobe from the FIFO head when the
  // PSG is ready, then wait (bounded) for READY to drop before the next one.
  always_comb begin
    state_d = state_q;
    nwe_d   = nwe_q;
    psg_d_d = psg_d_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && PSG_READY) begin
          pop     = 1'b1;
          psg_d_d = mem_q[rd_ptr_q];
          nwe_d   = 1'b0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        nwe_d   = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!PSG_READY) begin
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        nwe_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a byte on the edge it pops.
  always_comb begin
    push     = BUS_WR && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control and output registers; reset forces the strobe high at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      nwe_q    <= 1'b1;
      psg_d_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      nwe_q    <= nwe_d;
      psg_d_q  <= psg_d_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= BUS_D;
    end
  end

`ifdef PSG_WRQ_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: any write that found the FIFO full with no pop is lost.
  always_comb begin
    ovf_d = ovf_q | (BUS_WR && !push);
  end

  // Overflow flag register, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign BUS_OVF = ovf_q;
`else
  assign BUS_OVF = 1'b0;
`endif

endmodule

// File: tb/tb_psg_write_queue.sv
`timescale 1ns/1ps
// tb_psg_write_queue
// Directed bench with a byte scoreboard and a behavioural PSG model that
// decodes latch/data bytes into tone/volume registers.
module tb_psg_write_queue;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       BUS_WR;
  logic [7:0] BUS_D;
  logic       BUS_FULL;
  logic       BUS_OVF;
  logic       PSG_nWE;
  logic       PSG_nCE;
  logic [7:0] PSG_D;
  logic       PSG_READY;

  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         ready_mode = 0;
  logic       ready_model;
  logic       prev_nwe = 1'b1;
  logic [7:0] sb [$];
  int         strobe_cyc [$];
  logic [2:0] latch_reg = 3'd0;
  logic [9:0] psg_regs [8];

`ifdef PSG_WRQ_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  psg_write_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .BUS_WR   (BUS_WR),
    .BUS_D    (BUS_D),
    .BUS_FULL (BUS_FULL),
    .BUS_OVF  (BUS_OVF),
    .PSG_nWE  (PSG_nWE),
    .PSG_nCE  (PSG_nCE),
    .PSG_D    (PSG_D),
    .PSG_READY(PSG_READY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // READY source: 0 = PSG model (low one cycle after each write), 1 = stuck low, 2 = stuck high
  assign PSG_READY = (ready_mode == 1) ? 1'b0 : (ready_mode == 2) ? 1'b1 : ready_model;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) ready_model <= 1'b1;
    else       ready_model <= PSG_nWE;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // PSG model: samples D on each edge where the strobe is low
  always @(posedge CLK) begin
    if (nRST === 1'b1 && PSG_nWE === 1'b0) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      checkOutput("strobe_width", prev_nwe, 1);
      checkOutput("nce_follows_nwe", PSG_nCE, 0);
      checkOutput("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) checkOutput("psg_d_order", PSG_D, sb.pop_front());
      if (PSG_D[7]) begin
        latch_reg = PSG_D[6:4];
        if (!PSG_D[4] && PSG_D[6:4] != 3'd6) psg_regs[PSG_D[6:4]][3:0] = PSG_D[3:0];
        else psg_regs[PSG_D[6:4]] = {6'd0, PSG_D[3:0]};
      end else begin
        if (!latch_reg[0] && latch_reg != 3'd6) psg_regs[latch_reg][9:4] = PSG_D[5:0];
        else psg_regs[latch_reg][3:0] = PSG_D[3:0];
      end
    end
    prev_nwe <= PSG_nWE;
  end

  // Drive bus inputs for one clock; called at a falling edge, returns at the next
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic accept);
    BUS_WR = wr;
    BUS_D  = d;
    if (wr && accept) sb.push_back(d);
    @(negedge CLK);
  endtask

  task automatic waitDrain(input string tag, input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || PSG_nWE == 1'b0) && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    repeat (8) @(negedge CLK);
    checkOutput(tag, sb.size(), 0);
  endtask

  task automatic pulseReset();
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    bit found;
    for (int i = 0; i < 8; i++) psg_regs[i] = 10'd0;
    nRST = 1'b0;
    BUS_WR = 1'b0;
    BUS_D = 8'h00;
    @(negedge CLK);

    // Reset with bus writes pulsing
    for (int i = 0; i < 4; i++) applyStimulus(i % 2 == 0, 8'hEE, 1'b0);
    checkOutput("rst_nwe", PSG_nWE, 1);
    checkOutput("rst_nce", PSG_nCE, 1);
    checkOutput("rst_d", PSG_D, 8'h00);
    checkOutput("rst_full", BUS_FULL, 0);
    checkOutput("rst_ovf", BUS_OVF, 0);
    BUS_WR = 1'b0;
    nRST = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("rst_no_strobe", strobe_cnt, 0);

    // Single write and latency
    applyStimulus(1'b1, 8'h9F, 1'b1);
    checkOutput("lat_edge_k", PSG_nWE, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lat_edge_k1_nwe", PSG_nWE, 0);
    checkOutput("lat_edge_k1_d", PSG_D, 8'h9F);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lat_edge_k2_nwe", PSG_nWE, 1);
    waitDrain("single_drain", 50);
    checkOutput("vol0", psg_regs[1][3:0], 4'hF);

    // Burst of four back-to-back writes
    strobe_cyc.delete();
    applyStimulus(1'b1, 8'h80, 1'b1);
    applyStimulus(1'b1, 8'h2A, 1'b1);
    applyStimulus(1'b1, 8'hA5, 1'b1);
    applyStimulus(1'b1, 8'h13, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitDrain("burst_drain", 100);
    checkOutput("burst_strobes", strobe_cyc.size(), 4);
    for (int i = 1; i < strobe_cyc.size(); i++)
      checkOutput("burst_spacing", strobe_cyc[i] - strobe_cyc[i-1], 3);
    checkOutput("tone0", psg_regs[0], 10'h2A0);
    checkOutput("tone1_lo", psg_regs[2][3:0], 4'h5);
    checkOutput("tone1_hi", psg_regs[2][9:4], 6'h13);

    // Overflow with READY held low
    ready_mode = 1;
    base = strobe_cnt;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      applyStimulus(1'b1, 8'(i), i <= DEPTH);
      if (i == DEPTH) checkOutput("ovf_full_at_depth", BUS_FULL, 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf_full_hold", BUS_FULL, 1);
    checkOutput("ovf_flag", BUS_OVF, OVF_EXP);
    checkOutput("ovf_no_strobe", strobe_cnt - base, 0);
    ready_mode = 0;
    waitDrain("ovf_drain", 200);
    checkOutput("ovf_drain_count", strobe_cnt - base, DEPTH);
    checkOutput("ovf_sticky", BUS_OVF, OVF_EXP);
    checkOutput("ovf_empty", BUS_FULL, 0);

    // Full FIFO with push on the pop edge
    pulseReset();
    checkOutput("ovf_cleared", BUS_OVF, 0);
    ready_mode = 1;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'h11 + 8'(i), 1'b1);
    checkOutput("fp_full", BUS_FULL, 1);
    ready_mode = 0;
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("fp_count_held", BUS_FULL, 1);
    checkOutput("fp_ovf_pop_edge", BUS_OVF, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitDrain("fp_drain", 200);
    checkOutput("fp_ovf_final", BUS_OVF, 0);

    // READY stuck high: strobes paced by the timeout
    ready_mode = 2;
    strobe_cyc.delete();
    applyStimulus(1'b1, 8'hC1, 1'b1);
    applyStimulus(1'b1, 8'hC2, 1'b1);
    applyStimulus(1'b1, 8'hC3, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitDrain("stuck_drain", 100);
    checkOutput("stuck_strobes", strobe_cyc.size(), 3);
    for (int i = 1; i < strobe_cyc.size(); i++)
      checkOutput("stuck_spacing", strobe_cyc[i] - strobe_cyc[i-1], TIMEOUT + 2);

    // Reset asserted in the middle of a strobe
    applyStimulus(1'b1, 8'hD1, 1'b1);
    applyStimulus(1'b1, 8'hD2, 1'b1);
    applyStimulus(1'b1, 8'hD3, 1'b1);
    BUS_WR = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(posedge CLK);
      #2;
      if (PSG_nWE === 1'b0) found = 1'b1;
    end
    checkOutput("midrst_strobe_seen", found, 1);
    base = strobe_cnt;
    nRST = 1'b0;
    #1;
    checkOutput("midrst_nwe", PSG_nWE, 1);
    checkOutput("midrst_nce", PSG_nCE, 1);
    checkOutput("midrst_full", BUS_FULL, 0);
    sb.delete();
    @(negedge CLK);
    nRST = 1'b1;
    repeat (30) @(negedge CLK);
    checkOutput("midrst_no_strobe", strobe_cnt - base, 0);
    checkOutput("midrst_idle_nwe", PSG_nWE, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/psg_write_queue.md
# psg_write_queue

Bus-side write buffer and strobe sequencer sitting directly upstream of the PSG tone/noise generator. Absorbs CPU byte writes (latch/data command bytes) into a small FIFO at bus speed, then replays them one at a time onto the PSG's nWE/nCE/D port, pacing each write by the PSG's READY output so no command byte is lost while the PSG is in its post-write LATCH/DATA cycle.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- TIMEOUT, 4, cycles to wait for READY to fall after a strobe before abandoning the wait.

Ports:
- CLK  input  1  system clock, same clock as the PSG.
- nRST  input  1  asynchronous active-low reset.
- BUS_WR  input  1  one-cycle write strobe from bus decode; sampled on rising CLK.
- BUS_D  input  8  command byte, valid with BUS_WR.
- BUS_FULL  output  1  FIFO holds DEPTH entries.
- BUS_OVF  output  1  sticky overflow flag (see Configuration).
- PSG_nWE  output  1  active-low write enable to PSG; registered.
- PSG_nCE  output  1  active-low chip enable to PSG; registered, always equal to PSG_nWE.
- PSG_D  output  8  command byte to PSG; registered.
- PSG_READY  input  1  PSG ready; high when the PSG accepts a write.

## Operation
- FIFO: DEPTH×8 storage, write pointer, read pointer, count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: on a rising edge with BUS_WR=1, BUS_D is written at the write pointer if count<DEPTH, or count==DEPTH with a pop on the same edge. Otherwise the byte is dropped. The FIFO contents are never altered.
- Pop: occurs on the edge that leaves IDLE for STROBE.
- Simultaneous push and pop leaves count unchanged.
- BUS_FULL = (count==DEPTH), combinational from count.
- State machine:
  - IDLE: if count≠0 and PSG_READY=1, then on the edge: PSG_D←head, PSG_nWE/PSG_nCE←0, pop, go to STROBE. Otherwise stay in IDLE.
  - STROBE: one cycle only. On the edge: PSG_nWE/PSG_nCE←1, timeout counter←0, go to WAIT_LO.
  - WAIT_LO: if PSG_READY=0, go to IDLE. Else increment the timeout counter; when it reaches TIMEOUT−1, go to IDLE anyway.
- PSG_D holds its last value outside STROBE.
- Bytes are forwarded strictly in arrival order and unmodified. Bit 7 latch/data semantics are the PSG's concern.

## Timing
- Reset values: PSG_nWE=1, PSG_nCE=1, PSG_D=0, BUS_FULL=0, BUS_OVF=0, state=IDLE, FIFO empty.
- Reset asserted mid-strobe forces the strobe high immediately (asynchronously) and discards queued bytes.
- Latency: BUS_WR sampled at edge k into an empty FIFO with READY=1 gives strobe low during cycle k+1..k+2 (asserted at edge k+1, released at edge k+2).
- Throughput against a PSG whose READY is low exactly one cycle after each write: one write per 3 cycles (STROBE, WAIT_LO, IDLE).
- Strobe low width is exactly 1 cycle, so the PSG samples each byte exactly once.
- With READY stuck high: one write per TIMEOUT+2 cycles.
- With READY stuck low: the queue stalls in IDLE and fills. BUS_FULL asserts at count==DEPTH.

## Configuration
- PSG_WRQ_OVF_EN defined:
  - BUS_OVF sets on any edge where a push is dropped (BUS_WR=1, full, no pop).
  - BUS_OVF stays set until nRST.
- PSG_WRQ_OVF_EN undefined:
  - BUS_OVF is tied to 0 and its register is not built.
  - Drop behaviour is unchanged.

## Test plan
- Reset: nRST low with BUS_WR pulsing. Required: PSG_nWE=PSG_nCE=1, PSG_D=0x00, BUS_FULL=0, BUS_OVF=0, no strobe.
- Single write: BUS_D=0x9F with the model PSG (READY low one cycle after each write). Required: strobe low exactly one cycle starting 1 edge after push, PSG_D=0x9F during it; the PSG sets vol0=0xF.
- Burst: back-to-back writes 0x80, 0x2A, 0xA5, 0x13. Required: PSG sees strobes in that order, 3 cycles apart; the PSG ends with tone0=0x2A0 and tone1 low nibble=0x5 (upper bits 0x13).
- Overflow: READY held 0, DEPTH+2 writes 0x01..0x0A with DEPTH=8. Required: BUS_FULL=1 after the 8th write; 0x09 and 0x0A are dropped; BUS_OVF=1 (macro on) or 0 (macro off). After READY is released, exactly 0x01..0x08 emerge.
- Full plus simultaneous pop: FIFO full, READY rises, and BUS_WR=0x55 arrives on the pop edge. Required: 0x55 is accepted, count stays 8, 0x55 emerges last, BUS_OVF stays 0.
- READY stuck high and mid-reset: with TIMEOUT=4, 3 queued bytes give strobes 6 cycles apart. nRST pulsed low during a strobe gives immediate nWE=1, an empty FIFO, and no further strobes.
